// File: rtl/pe_row_q.sv
// rtl/pe_row_q.sv - one row of weight-stationary-free MAC columns with per-column requantised result
module pe_row_q #(
    parameter int ARRAY_NUM = 4,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24,
    parameter int SHIFT_W   = 5
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iValid,
    input  logic                          iClearAcc,
    input  logic [DATA_W-1:0]             iWeight,
    input  logic [DATA_W*ARRAY_NUM-1:0]   iData,
    input  logic [ARRAY_NUM-2:0]          iCfsPassDataLeft,
    input  logic [SHIFT_W-1:0]            iCfsOutputShift,
    input  logic                          iCfsRound,
    output logic [DATA_W-1:0]             oWeight,
    output logic                          oValid,
    output logic                          oClearAcc,
    output logic [DATA_W*ARRAY_NUM-1:0]   oResult,
    output logic [ARRAY_NUM-1:0]          oResultValid,
    output logic [ARRAY_NUM-1:0]          oSat
);

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

    logic        [DATA_W-1:0] w_stg [ARRAY_NUM];
    logic        [ARRAY_NUM-1:0] v_stg;
    logic        [ARRAY_NUM-1:0] c_stg;
    logic        [DATA_W-1:0] d_reg [ARRAY_NUM];
    logic signed [ACC_W-1:0]  acc   [ARRAY_NUM];
    logic signed [ACC_W-1:0]  prod  [ARRAY_NUM];
    logic signed [ACC_W:0]    ext   [ARRAY_NUM];
    logic signed [ACC_W:0]    shf   [ARRAY_NUM];
    logic        [DATA_W-1:0] rq_val [ARRAY_NUM];
    logic        [ARRAY_NUM-1:0] rq_sat;
    int                       shift_amt;

    assign shift_amt = int'(iCfsOutputShift);

    // Requant works on one extra bit so the rounding add can never overflow.
    always_comb begin
        rq_sat = '0;
        for (int i = 0; i < ARRAY_NUM; i++) begin
            prod[i] = ACC_W'($signed(d_reg[i])) * ACC_W'($signed(w_stg[i]));
            ext[i]  = {acc[i][ACC_W-1], acc[i]};
            if (iCfsRound && shift_amt > 0 && shift_amt < ACC_W)
                ext[i] = ext[i] + ((ACC_W+1)'(1) << (shift_amt - 1));
            if (shift_amt >= ACC_W)
                shf[i] = acc[i][ACC_W-1] ? '1 : '0;
            else
                shf[i] = ext[i] >>> shift_amt;
            rq_val[i] = shf[i][DATA_W-1:0];
            if (shf[i] > SAT_HI) begin
                rq_val[i] = SAT_HI[DATA_W-1:0];
                rq_sat[i] = 1'b1;
            end else if (shf[i] < SAT_LO) begin
                rq_val[i] = SAT_LO[DATA_W-1:0];
                rq_sat[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < ARRAY_NUM; i++) begin
                w_stg[i] <= '0;
                d_reg[i] <= '0;
                acc[i]   <= '0;
            end
            v_stg        <= '0;
            c_stg        <= '0;
            oResult      <= '0;
            oResultValid <= '0;
            oSat         <= '0;
        end else begin
            w_stg[0] <= iWeight;
            for (int i = 1; i < ARRAY_NUM; i++)
                w_stg[i] <= w_stg[i-1];
            v_stg <= {v_stg[ARRAY_NUM-2:0], iValid};
            c_stg <= {c_stg[ARRAY_NUM-2:0], iClearAcc};

            d_reg[ARRAY_NUM-1] <= iData[(ARRAY_NUM-1)*DATA_W +: DATA_W];
            for (int i = 0; i < ARRAY_NUM - 1; i++) begin
                if (iCfsPassDataLeft[i])
                    d_reg[i] <= d_reg[i+1];
                else
                    d_reg[i] <= iData[i*DATA_W +: DATA_W];
            end

            // A clear dumps the pre-update sum and restarts with this beat's product.
            for (int i = 0; i < ARRAY_NUM; i++) begin
                oResultValid[i] <= c_stg[i];
                oSat[i]         <= c_stg[i] & rq_sat[i];
                if (c_stg[i]) begin
                    oResult[i*DATA_W +: DATA_W] <= rq_val[i];
                    acc[i] <= v_stg[i] ? prod[i] : '0;
                end else if (v_stg[i]) begin
                    acc[i] <= acc[i] + prod[i];
                end
            end
        end
    end

    assign oWeight   = w_stg[ARRAY_NUM-1];
    assign oValid    = v_stg[ARRAY_NUM-1];
    assign oClearAcc = c_stg[ARRAY_NUM-1];

endmodule
